// File: rtl/alu_operand_stage_if.sv
// Bundle of the operand stage's handshake, issue, result and writeback signals.
//   slave  : modport used by the operand stage itself
//   master : modport for the upstream issue logic / ALU-writeback side
// Signals:
//   in_valid/in_ready         instruction handshake into the stage
//   in_op, in_ra, in_rb, in_rd, in_use_imm, in_imm   instruction fields
//   out_valid/out_ready       handshake toward the ALU
//   inputa, inputb, op, out_rd registered operands/opcode/destination
//   wb_en, wb_addr, wb_data   register-file writeback port
//   stall_cnt                 saturating back-pressure cycle counter
interface alu_operand_stage_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned OPW  = 3,
  parameter int unsigned IMMW = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_op;
  logic [AW-1:0]   in_ra;
  logic [AW-1:0]   in_rb;
  logic [AW-1:0]   in_rd;
  logic            in_use_imm;
  logic [IMMW-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   inputa;
  logic [DW-1:0]   inputb;
  logic [OPW-1:0]  op;
  logic [AW-1:0]   out_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [7:0]      stall_cnt;

  modport slave (
    input  in_valid, in_op, in_ra, in_rb, in_rd, in_use_imm, in_imm,
    input  out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, inputa, inputb, op, out_rd, stall_cnt
  );

  modport master (
    output in_valid, in_op, in_ra, in_rb, in_rd, in_use_imm, in_imm,
    output out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, inputa, inputb, op, out_rd, stall_cnt
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage in front of the 8-bit combinational ALU.
// Holds the register file, reads two sources per instruction with same-cycle
// writeback forwarding, selects register or zero-extended immediate for
// operand B, and presents inputa/inputb/op/out_rd from a single-entry output
// register behind a valid/ready handshake.
// Ports:
//   clk      clock, all state on posedge
//   reset_n  synchronous active-low reset
//   bus      alu_operand_stage_if.slave (handshake, operands, writeback, stall_cnt)
module alu_operand_stage #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned OPW  = 3,
  parameter int unsigned IMMW = 3
) (
  input logic                clk,
  input logic                reset_n,
  alu_operand_stage_if.slave bus
);

  localparam int unsigned NSlots = 2 ** AW;

  // Slots at or above NREG are never written, so they stay at reset zero.
  logic [DW-1:0]  rf_q [NSlots];

  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  inputa_q, inputa_d;
  logic [DW-1:0]  inputb_q, inputb_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  out_rd_q, out_rd_d;
  logic [7:0]     stall_cnt_q, stall_cnt_d;

  logic           accept;
  logic [DW-1:0]  src_a, src_b, opnd_b;

  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return 32'(addr) < NREG;
  endfunction

  // Source read with writeback bypass so a dependent instruction issued in the
  // same cycle as its producer's writeback sees the new value.
  always_comb begin
    src_a = '0;
    src_b = '0;
    if (addr_ok(bus.in_ra)) begin
      src_a = (bus.wb_en && bus.wb_addr == bus.in_ra) ? bus.wb_data : rf_q[bus.in_ra];
    end
    if (addr_ok(bus.in_rb)) begin
      src_b = (bus.wb_en && bus.wb_addr == bus.in_rb) ? bus.wb_data : rf_q[bus.in_rb];
    end
    opnd_b = bus.in_use_imm ? {{(DW - IMMW){1'b0}}, bus.in_imm} : src_b;
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    inputa_d    = inputa_q;
    inputb_d    = inputb_q;
    op_d        = op_q;
    out_rd_d    = out_rd_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      inputa_d    = src_a;
      inputb_d    = opnd_b;
      op_d        = bus.in_op;
      out_rd_d    = bus.in_rd;
    end else if (out_valid_q && bus.out_ready) begin
      // Drain: outputs keep their last values, only valid drops.
      out_valid_d = 1'b0;
    end
    if (out_valid_q && !bus.out_ready && stall_cnt_q != 8'hFF) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSlots; i++) begin
        rf_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      inputa_q    <= '0;
      inputb_q    <= '0;
      op_q        <= '0;
      out_rd_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NSlots; i++) begin
        if (bus.wb_en && bus.wb_addr == AW'(i) && i < NREG) begin
          rf_q[i] <= bus.wb_data;
        end
      end
      out_valid_q <= out_valid_d;
      inputa_q    <= inputa_d;
      inputb_q    <= inputb_d;
      op_q        <= op_d;
      out_rd_q    <= out_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.inputa    = inputa_q;
  assign bus.inputb    = inputb_q;
  assign bus.op        = op_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_alu_operand_stage;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned OPW  = 3;
  localparam int unsigned IMMW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.DW(DW), .AW(AW), .OPW(OPW), .IMMW(IMMW)) bus ();

  alu_operand_stage #(
    .DW(DW), .NREG(NREG), .AW(AW), .OPW(OPW), .IMMW(IMMW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_rf [NREG];
  bit m_valid;
  int m_a, m_b, m_op, m_rd, m_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_read(input int addr);
    if (bus.wb_en && int'(bus.wb_addr) == addr) return int'(bus.wb_data);
    return m_rf[addr];
  endfunction

  task automatic set_idle();
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_ra      = '0;
    bus.in_rb      = '0;
    bus.in_rd      = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.out_ready  = 1'b1;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
  endtask

  task automatic issue(input int op, input int ra, input int rb, input int rd,
                       input bit use_imm, input int imm);
    bus.in_valid   = 1'b1;
    bus.in_op      = OPW'(op);
    bus.in_ra      = AW'(ra);
    bus.in_rb      = AW'(rb);
    bus.in_rd      = AW'(rd);
    bus.in_use_imm = use_imm;
    bus.in_imm     = IMMW'(imm);
  endtask

  task automatic wb(input int addr, input int data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = AW'(addr);
    bus.wb_data = DW'(data);
  endtask

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic do_cycle();
    bit ready;
    bit accept;
    #1;
    ready = !m_valid || bus.out_ready;
    check_eq("in_ready", 32'(bus.in_ready), 32'(ready));
    if (!reset_n) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_stall = 0;
    end else begin
      accept = bus.in_valid && ready;
      if (m_valid && !bus.out_ready) m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
      if (accept) begin
        m_valid = 1;
        m_a  = model_read(int'(bus.in_ra));
        m_b  = bus.in_use_imm ? int'(bus.in_imm) : model_read(int'(bus.in_rb));
        m_op = int'(bus.in_op);
        m_rd = int'(bus.in_rd);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      if (bus.wb_en) m_rf[int'(bus.wb_addr)] = int'(bus.wb_data);
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_eq("inputa",    32'(bus.inputa),    m_a);
    check_eq("inputb",    32'(bus.inputb),    m_b);
    check_eq("op",        32'(bus.op),        m_op);
    check_eq("out_rd",    32'(bus.out_rd),    m_rd);
    check_eq("stall_cnt", 32'(bus.stall_cnt), m_stall);
  endtask

  initial begin
    set_idle();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_stall = 0;

    // Reset state
    reset_n = 1'b0;
    do_cycle();
    check_eq("rst_valid", 32'(bus.out_valid), 0);
    check_eq("rst_a",     32'(bus.inputa), 0);
    check_eq("rst_b",     32'(bus.inputb), 0);
    check_eq("rst_stall", 32'(bus.stall_cnt), 0);
    check_eq("rst_ready", 32'(bus.in_ready), 1);
    reset_n = 1'b1;

    // All registers read back zero
    for (int i = 0; i < 8; i++) begin
      issue(0, i, i, i, 1'b0, 0);
      do_cycle();
      check_eq("rf_zero_a", 32'(bus.inputa), 0);
      check_eq("rf_zero_b", 32'(bus.inputb), 0);
    end

    // Writeback then dependent read
    set_idle();
    wb(3, 8'h5A);
    do_cycle();
    set_idle();
    issue(0, 3, 3, 3, 1'b0, 0);
    do_cycle();
    check_eq("wb_valid", 32'(bus.out_valid), 1);
    check_eq("wb_a",     32'(bus.inputa), 32'h5A);
    check_eq("wb_b",     32'(bus.inputb), 32'h5A);
    check_eq("wb_op",    32'(bus.op), 0);

    // Same-cycle forwarding
    set_idle();
    wb(2, 8'h11);
    issue(0, 2, 2, 1, 1'b0, 0);
    do_cycle();
    check_eq("fwd_a", 32'(bus.inputa), 32'h11);
    check_eq("fwd_b", 32'(bus.inputb), 32'h11);

    // Immediate of zero
    set_idle();
    wb(1, 8'h81);
    do_cycle();
    set_idle();
    issue(3'b010, 1, 0, 0, 1'b1, 0);
    do_cycle();
    check_eq("imm_a",  32'(bus.inputa), 32'h81);
    check_eq("imm_b",  32'(bus.inputb), 0);
    check_eq("imm_op", 32'(bus.op), 2);

    // Back-pressure for three cycles, then no-bubble accept
    set_idle();
    issue(5, 3, 2, 7, 1'b0, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      check_eq("bp_ready", 32'(bus.in_ready), 0);
      check_eq("bp_hold_a", 32'(bus.inputa), 32'h81);
    end
    check_eq("bp_stall", 32'(bus.stall_cnt), 3);
    bus.out_ready = 1'b1;
    do_cycle();
    check_eq("bp_valid", 32'(bus.out_valid), 1);
    check_eq("bp_new_a", 32'(bus.inputa), 32'h5A);
    check_eq("bp_new_b", 32'(bus.inputb), 32'h11);
    check_eq("bp_new_op", 32'(bus.op), 5);

    // Reset mid-operation discards the writeback
    set_idle();
    bus.out_ready = 1'b0;
    do_cycle();
    do_cycle();
    check_eq("mid_stall", 32'(bus.stall_cnt), 5);
    reset_n = 1'b0;
    wb(4, 8'h77);
    do_cycle();
    check_eq("mid_valid", 32'(bus.out_valid), 0);
    check_eq("mid_stall0", 32'(bus.stall_cnt), 0);
    reset_n = 1'b1;
    set_idle();
    issue(0, 4, 4, 4, 1'b0, 0);
    do_cycle();
    check_eq("mid_rf4", 32'(bus.inputa), 0);

    // Saturation of the stall counter
    set_idle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 300; i++) do_cycle();
    check_eq("sat_stall", 32'(bus.stall_cnt), 32'hFF);
    set_idle();
    do_cycle();
    check_eq("sat_keep", 32'(bus.stall_cnt), 32'hFF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n        = ($urandom_range(0, 199) != 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_op      = OPW'($urandom);
      bus.in_ra      = AW'($urandom);
      bus.in_rb      = AW'($urandom);
      bus.in_rd      = AW'($urandom);
      bus.in_use_imm = $urandom_range(0, 1) != 0;
      bus.in_imm     = IMMW'($urandom);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.wb_en      = $urandom_range(0, 1) != 0;
      bus.wb_addr    = AW'($urandom);
      bus.wb_data    = DW'($urandom);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
